fft8_bitrev_loader: RTL and testbench

//  Input stage of the 8-point radix-2 DIT FFT pipeline. Collects a serial

---
 rtl/fft8_bitrev_loader.sv | 66 ++++++
 tb/tb_fft8_bitrev_loader.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fft8_bitrev_loader.sv
// fft8_bitrev_loader: ping-pong loader that reorders 8-sample frames into bit-reversed order for the FFT pipeline
module fft8_bitrev_loader #(
  parameter int DW   = 64,
  parameter int NPTS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          s_sof,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] o0,
  output logic [DW-1:0] o1,
  output logic [DW-1:0] o2,
  output logic [DW-1:0] o3,
  output logic [DW-1:0] o4,
  output logic [DW-1:0] o5,
  output logic [DW-1:0] o6,
  output logic [DW-1:0] o7,
  output logic          err_sof
);
  logic [DW-1:0] bank [2][NPTS];
  logic [1:0] full, full_n;
  logic wr_bank, rd_bank, acc, last, rel;
  logic [2:0] wr_cnt, idx;
  function automatic logic [2:0] bitrev3(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction
  assign s_ready = !full[wr_bank];
  assign m_valid = full[rd_bank];
  assign acc     = s_valid && s_ready;
  assign idx     = s_sof ? 3'd0 : wr_cnt;
  assign last    = acc && idx == 3'd7;
  assign rel     = m_valid && m_ready;
  // completion and release always hit different banks, so both updates can merge
  assign full_n  = (full & ~({1'b0, rel} << rd_bank)) | ({1'b0, last} << wr_bank);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < NPTS; k++)
          bank[b][k] <= '0;
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      err_sof <= 1'b0;
    end else begin
      if (acc) bank[wr_bank][bitrev3(idx)] <= s_data;
      if (acc) wr_cnt <= idx + 3'd1;
      full    <= full_n;
      wr_bank <= wr_bank ^ last;
      rd_bank <= rd_bank ^ rel;
      err_sof <= acc && s_sof && wr_cnt != 3'd0;
    end
  end
  assign o0 = bank[rd_bank][0];
  assign o1 = bank[rd_bank][1];
  assign o2 = bank[rd_bank][2];
  assign o3 = bank[rd_bank][3];
  assign o4 = bank[rd_bank][4];
  assign o5 = bank[rd_bank][5];
  assign o6 = bank[rd_bank][6];
  assign o7 = bank[rd_bank][7];
endmodule

// File: tb/tb_fft8_bitrev_loader.sv
// tb_fft8_bitrev_loader: randomized scoreboard bench for the bit-reversing frame loader
module tb_fft8_bitrev_loader;
  typedef logic [7:0][63:0] frame_t;
  logic clk, rst_n, s_valid, s_ready, s_sof, m_valid, m_ready, err_sof;
  logic [63:0] s_data, o0, o1, o2, o3, o4, o5, o6, o7;
  int checks = 0, errors = 0;
  int mode = 0;
  frame_t q[$];
  logic [63:0] xm [8];
  int mcnt = 0, idx_m;
  bit err_exp = 0, zero_exp = 1, rdy_m;
  frame_t f, o_act;
  logic [31:0] fl [8];

  fft8_bitrev_loader dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7),
    .err_sof(err_sof)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    #1;
    m_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rev3(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  // model: banks full == frames queued; output frame is the queue head
  always @(negedge clk) begin
    o_act = {o7, o6, o5, o4, o3, o2, o1, o0};
    if (!rst_n) begin
      chk("rst_m_valid", 512'(m_valid), 512'(0));
      chk("rst_s_ready", 512'(s_ready), 512'(1));
      chk("rst_err_sof", 512'(err_sof), 512'(0));
      chk("rst_outputs", o_act, 512'(0));
      q.delete();
      mcnt = 0;
      err_exp = 0;
      zero_exp = 1;
    end else begin
      rdy_m = q.size() < 2;
      chk("m_valid", 512'(m_valid), 512'(q.size() > 0));
      chk("s_ready", 512'(s_ready), 512'(rdy_m));
      chk("err_sof", 512'(err_sof), 512'(err_exp));
      if (q.size() > 0) chk("frame", o_act, q[0]);
      else if (zero_exp) chk("zero_outputs", o_act, 512'(0));
      err_exp = 0;
      if (m_ready && q.size() > 0) void'(q.pop_front());
      if (s_valid && rdy_m) begin
        zero_exp = 0;
        idx_m = s_sof ? 0 : mcnt;
        if (s_sof && mcnt != 0) err_exp = 1;
        xm[idx_m] = s_data;
        if (idx_m == 7) begin
          for (int k = 0; k < 8; k++) f[k] = xm[rev3(k)];
          q.push_back(f);
          mcnt = 0;
        end else mcnt = idx_m + 1;
      end
    end
  end

  task automatic beat(input logic [63:0] d, input logic sof);
    int w;
    s_valid = 1;
    s_data = d;
    s_sof = sof;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!s_ready && w < 200);
    if (!s_ready) begin
      errors++;
      $display("FAIL beat_timeout: s_ready stayed 0 for %0d cycles", w);
    end
    @(posedge clk);
    #1;
    s_valid = 0;
    s_sof = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input int m);
    @(negedge clk);
    mode = m;
    @(posedge clk);
    #1;
  endtask

  initial begin
    fl = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
           32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    rst_n = 0; s_valid = 0; s_sof = 0; s_data = 0; m_ready = 1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    idle(2);
    for (int n = 0; n < 8; n++) beat({fl[n], 32'h0}, n == 0);
    idle(4);
    for (int i = 0; i < 32; i++) beat({$urandom, $urandom}, i % 8 == 0);
    idle(4);
    set_mode(1);
    for (int i = 0; i < 16; i++) beat({$urandom, $urandom}, i % 8 == 0);
    s_valid = 1; s_data = {$urandom, $urandom}; s_sof = 1;
    repeat (8) @(negedge clk);
    mode = 0;
    @(negedge clk);
    mode = 1;
    @(posedge clk);
    #1;
    s_valid = 0; s_sof = 0;
    idle(3);
    for (int i = 0; i < 7; i++) begin
      beat({$urandom, $urandom}, 0);
      idle(2);
    end
    set_mode(0);
    idle(6);
    for (int i = 0; i < 3; i++) beat({$urandom, $urandom}, i == 0);
    for (int i = 0; i < 8; i++) beat({$urandom, $urandom}, i == 0);
    idle(4);
    set_mode(1);
    for (int i = 0; i < 13; i++) beat({$urandom, $urandom}, i % 8 == 0);
    idle(2);
    rst_n = 0;
    @(posedge clk);
    #3 rst_n = 1;
    set_mode(0);
    for (int i = 0; i < 8; i++) beat({$urandom, $urandom}, i == 0);
    idle(4);
    set_mode(2);
    for (int i = 0; i < 300; i++) begin
      beat({$urandom, $urandom}, $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    set_mode(0);
    idle(20);
    chk("drained", 512'(q.size()), 512'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
